// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES core scheduler.
// Contents:
//   DEFAULT_BLOCK_W - default AES block/key width
//   sched_state_e   - scheduler FSM states
//   req_id_t        - requester identifier (two requesters)
package aes_sched_pkg;

    localparam int DEFAULT_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   valid0, valid1 - requester pending flags
//   last_grant     - requester granted most recently
//   grant          - one-hot grant, bit N set for requester N, zero if none valid
module rr_arb2
    import aes_sched_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            // Contention: favour whoever did not win last time.
            grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one pin-level AES encryption core between two requesters.
// One operation at a time: accept a request (IDLE), wait the fixed core
// latency (WAIT), then present the result until consumed (RESP).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   reqN_valid/ready               - request handshake for requester N (0/1)
//   reqN_plaintext, reqN_key       - request payload
//   resp_valid/ready               - response handshake
//   resp_id                        - owner of the response
//   resp_cipher_text, resp_keyout  - captured core results
//   core_plaintext, core_key       - registered drive to the AES core
//   core_cipher_text, core_keyout  - AES core results
//   busy                           - an operation is in progress
module aes_core_sched
    import aes_sched_pkg::*;
#(
    parameter int CORE_LATENCY = 10,
    parameter int BLOCK_W      = DEFAULT_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [BLOCK_W-1:0] req0_plaintext,
    input  logic [BLOCK_W-1:0] req0_key,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [BLOCK_W-1:0] req1_plaintext,
    input  logic [BLOCK_W-1:0] req1_key,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic [BLOCK_W-1:0] resp_cipher_text,
    output logic [BLOCK_W-1:0] resp_keyout,
    output logic [BLOCK_W-1:0] core_plaintext,
    output logic [BLOCK_W-1:0] core_key,
    input  logic [BLOCK_W-1:0] core_cipher_text,
    input  logic [BLOCK_W-1:0] core_keyout,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(CORE_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    sched_state_e     state;
    logic [CNT_W-1:0] cnt;
    req_id_t          owner;
    req_id_t          last_grant;
    logic [1:0]       grant;
    logic             busy_q;
    logic             resp_valid_q;
    logic             hs0;
    logic             hs1;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Readies and status are forced low during the reset cycle so that an
    // abandoned operation can neither hand out a grant nor a response.
    assign req0_ready = !rst && (state == IDLE) && grant[0];
    assign req1_ready = !rst && (state == IDLE) && grant[1];
    assign resp_valid = !rst && resp_valid_q;
    assign busy       = !rst && busy_q;

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            owner            <= 1'b0;
            last_grant       <= 1'b1;
            busy_q           <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_id          <= 1'b0;
            resp_cipher_text <= '0;
            resp_keyout      <= '0;
            core_plaintext   <= '0;
            core_key         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 || hs1) begin
                        core_plaintext <= hs1 ? req1_plaintext : req0_plaintext;
                        core_key       <= hs1 ? req1_key : req0_key;
                        owner          <= hs1;
                        last_grant     <= hs1;
                        cnt            <= CNT_LOAD;
                        busy_q         <= 1'b1;
                        state          <= WAIT;
                    end
                end
                WAIT: begin
                    // Count reaches zero in the CORE_LATENCY-th WAIT cycle,
                    // when the core output has been settled long enough.
                    if (cnt == '0) begin
                        resp_cipher_text <= core_cipher_text;
                        resp_keyout      <= core_keyout;
                        resp_id          <= owner;
                        resp_valid_q     <= 1'b1;
                        state            <= RESP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
